// File: rtl/stack_db_ctrl.sv
// Switch-driven LIFO stack with per-switch synchroniser/debouncer/edge-detect,
// same-cycle replace, occupancy reporting and a sticky first-error code.
module stack_db_ctrl #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DB_CYCLES = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_sw,
  input  logic                         pop_sw,
  input  logic                         err_clr,
  input  logic [DATA_W-1:0]            data_in,
  output logic [DATA_W-1:0]            data_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         error,
  output logic [1:0]                   err_code
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;

  // Bit 0 = push, bit 1 = pop.
  logic [1:0] sw_raw;
  logic [1:0] sw_pulse;

  assign sw_raw = {pop_sw, push_sw};

  generate
    if (DB_CYCLES == 0) begin : g_bypass
      // Inputs are already clean single-cycle strobes.
      assign sw_pulse = sw_raw;
    end else begin : g_db
      localparam int unsigned DBC_W = $clog2(DB_CYCLES + 1);
      for (genvar i = 0; i < 2; i++) begin : g_sw
        logic             sync1;
        logic             sync2;
        logic             level;
        logic             level_d;
        logic             pulse;
        logic [DBC_W-1:0] db_cnt;

        // Synchronise, debounce and turn a rising debounced level into one pulse.
        always_ff @(posedge clk) begin
          if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            pulse   <= 1'b0;
            db_cnt  <= '0;
          end else begin
            sync1   <= sw_raw[i];
            sync2   <= sync1;
            level_d <= level;
            pulse   <= level & ~level_d;
            if (sync2 != level) begin
              if (db_cnt == DBC_W'(DB_CYCLES - 1)) begin
                level  <= ~level;
                db_cnt <= '0;
              end else begin
                db_cnt <= db_cnt + DBC_W'(1);
              end
            end else begin
              db_cnt <= '0;
            end
          end
        end

        assign sw_pulse[i] = pulse;
      end
    end
  endgenerate

  logic push_p;
  logic pop_p;
  assign push_p = sw_pulse[0];
  assign pop_p  = sw_pulse[1];

  logic [DATA_W-1:0] mem [DEPTH];

  logic              do_push;
  logic              do_pop;
  logic              do_repl;
  logic              ovf;
  logic              unf;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] pop_data;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Decode the requested operation against current occupancy.
  always_comb begin
    do_push  = 1'b0;
    do_pop   = 1'b0;
    do_repl  = 1'b0;
    ovf      = 1'b0;
    unf      = 1'b0;
    wr_idx   = IDX_W'(count);
    rd_idx   = IDX_W'(count - CNT_W'(2));
    pop_data = '0;
    if (push_p && pop_p) begin
      if (empty) unf = 1'b1;
      else       do_repl = 1'b1;
    end else if (push_p) begin
      if (full) ovf = 1'b1;
      else      do_push = 1'b1;
    end else if (pop_p) begin
      if (empty) unf = 1'b1;
      else       do_pop = 1'b1;
    end
    if (do_repl) wr_idx = IDX_W'(count - CNT_W'(1));
    if (count >= CNT_W'(2)) pop_data = mem[rd_idx];
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (!reset && (do_push || do_repl)) begin
      mem[wr_idx] <= data_in;
    end
  end

  // Occupancy, top-of-stack and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      data_out <= '0;
      error    <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      if (do_push) begin
        count    <= count + CNT_W'(1);
        data_out <= data_in;
      end else if (do_pop) begin
        count    <= count - CNT_W'(1);
        data_out <= pop_data;
      end else if (do_repl) begin
        data_out <= data_in;
      end

      // A new error beats a same-cycle clear; otherwise the first error is kept.
      if (ovf || unf) begin
        error <= 1'b1;
        if (!error || err_clr) err_code <= ovf ? ERR_OVF : ERR_UNF;
      end else if (err_clr) begin
        error    <= 1'b0;
        err_code <= ERR_NONE;
      end
    end
  end

endmodule

// File: tb/tb_stack_db_ctrl.sv
// Directed bench for stack_db_ctrl: strobe mode, debounced mode, non-power-of-2 depth.
module tb_stack_db_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // u0: DEPTH=4, strobe mode
  logic       rst = 1'b1;
  logic       p0_push = 1'b0, p0_pop = 1'b0, p0_clr = 1'b0;
  logic [7:0] p0_din = 8'h00;
  logic [7:0] d0;
  logic [2:0] c0;
  logic       f0, e0, er0;
  logic [1:0] ec0;

  // u1: DEPTH=16, DB_CYCLES=5
  logic       push1 = 1'b0, pop1 = 1'b0, clr1 = 1'b0;
  logic [7:0] din1 = 8'h00;
  logic [7:0] d1;
  logic [4:0] c1;
  logic       f1, e1, er1;
  logic [1:0] ec1;

  // u2: DEPTH=5, strobe mode
  logic       rst2 = 1'b1;
  logic       push2 = 1'b0, pop2 = 1'b0, clr2 = 1'b0;
  logic [7:0] din2 = 8'h00;
  logic [7:0] d2;
  logic [2:0] c2;
  logic       f2, e2, er2;
  logic [1:0] ec2;

  stack_db_ctrl #(.DATA_W(8), .DEPTH(4), .DB_CYCLES(0)) u0 (
    .clk(clk), .reset(rst), .push_sw(p0_push), .pop_sw(p0_pop), .err_clr(p0_clr),
    .data_in(p0_din), .data_out(d0), .count(c0), .full(f0), .empty(e0),
    .error(er0), .err_code(ec0));

  stack_db_ctrl #(.DATA_W(8), .DEPTH(16), .DB_CYCLES(5)) u1 (
    .clk(clk), .reset(rst), .push_sw(push1), .pop_sw(pop1), .err_clr(clr1),
    .data_in(din1), .data_out(d1), .count(c1), .full(f1), .empty(e1),
    .error(er1), .err_code(ec1));

  stack_db_ctrl #(.DATA_W(8), .DEPTH(5), .DB_CYCLES(0)) u2 (
    .clk(clk), .reset(rst2), .push_sw(push2), .pop_sw(pop2), .err_clr(clr2),
    .data_in(din2), .data_out(d2), .count(c2), .full(f2), .empty(e2),
    .error(er2), .err_code(ec2));

  // One strobe cycle on u0, outputs settled by the following negedge.
  task automatic op0(input logic pu, input logic po, input logic cl, input logic [7:0] d);
    @(negedge clk);
    p0_push = pu; p0_pop = po; p0_clr = cl; p0_din = d;
    @(negedge clk);
    p0_push = 1'b0; p0_pop = 1'b0; p0_clr = 1'b0;
  endtask

  task automatic op2(input logic pu, input logic [7:0] d);
    @(negedge clk);
    push2 = pu; din2 = d;
    @(negedge clk);
    push2 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst2 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; rst2 = 1'b0;
    n_cmp++; if (c0 !== 3'd0)  begin n_bad++; $display("FAIL rst_count got %0d want 0", c0); end
    n_cmp++; if (e0 !== 1'b1)  begin n_bad++; $display("FAIL rst_empty got %b want 1", e0); end
    n_cmp++; if (f0 !== 1'b0)  begin n_bad++; $display("FAIL rst_full got %b want 0", f0); end
    n_cmp++; if (d0 !== 8'h00) begin n_bad++; $display("FAIL rst_data got %h want 00", d0); end
    n_cmp++; if (er0 !== 1'b0) begin n_bad++; $display("FAIL rst_error got %b want 0", er0); end
    n_cmp++; if (ec0 !== 2'b00) begin n_bad++; $display("FAIL rst_code got %b want 00", ec0); end
    n_cmp++; if (c1 !== 5'd0)  begin n_bad++; $display("FAIL rst_count_db got %0d want 0", c1); end
  endtask

  task automatic test_push_full;
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      op0(1'b1, 1'b0, 1'b0, vals[i]);
      n_cmp++; if (d0 !== vals[i]) begin n_bad++; $display("FAIL push_data[%0d] got %h want %h", i, d0, vals[i]); end
    end
    n_cmp++; if (c0 !== 3'd4) begin n_bad++; $display("FAIL full_count got %0d want 4", c0); end
    n_cmp++; if (f0 !== 1'b1) begin n_bad++; $display("FAIL full_flag got %b want 1", f0); end
    n_cmp++; if (e0 !== 1'b0) begin n_bad++; $display("FAIL full_empty got %b want 0", e0); end
    op0(1'b1, 1'b0, 1'b0, 8'h55);
    n_cmp++; if (er0 !== 1'b1)  begin n_bad++; $display("FAIL ovf_error got %b want 1", er0); end
    n_cmp++; if (ec0 !== 2'b01) begin n_bad++; $display("FAIL ovf_code got %b want 01", ec0); end
    n_cmp++; if (d0 !== 8'h44)  begin n_bad++; $display("FAIL ovf_data got %h want 44", d0); end
    n_cmp++; if (c0 !== 3'd4)   begin n_bad++; $display("FAIL ovf_count got %0d want 4", c0); end
  endtask

  task automatic test_pop_errors;
    logic [7:0] exp_pop [4];
    exp_pop = '{8'h33, 8'h22, 8'h11, 8'h00};
    for (int i = 0; i < 4; i++) begin
      op0(1'b0, 1'b1, 1'b0, 8'h00);
      n_cmp++; if (d0 !== exp_pop[i]) begin n_bad++; $display("FAIL pop_data[%0d] got %h want %h", i, d0, exp_pop[i]); end
    end
    n_cmp++; if (e0 !== 1'b1) begin n_bad++; $display("FAIL pop_empty got %b want 1", e0); end
    n_cmp++; if (c0 !== 3'd0) begin n_bad++; $display("FAIL pop_count got %0d want 0", c0); end
    op0(1'b0, 1'b1, 1'b0, 8'h00);
    n_cmp++; if (ec0 !== 2'b01) begin n_bad++; $display("FAIL first_err_code got %b want 01", ec0); end
    n_cmp++; if (er0 !== 1'b1)  begin n_bad++; $display("FAIL first_err_flag got %b want 1", er0); end
    op0(1'b0, 1'b0, 1'b1, 8'h00);
    n_cmp++; if (er0 !== 1'b0)  begin n_bad++; $display("FAIL clr_error got %b want 0", er0); end
    n_cmp++; if (ec0 !== 2'b00) begin n_bad++; $display("FAIL clr_code got %b want 00", ec0); end
    op0(1'b0, 1'b1, 1'b0, 8'h00);
    n_cmp++; if (ec0 !== 2'b10) begin n_bad++; $display("FAIL unf_code got %b want 10", ec0); end
    n_cmp++; if (er0 !== 1'b1)  begin n_bad++; $display("FAIL unf_error got %b want 1", er0); end
  endtask

  task automatic test_replace;
    op0(1'b0, 1'b0, 1'b1, 8'h00);
    op0(1'b1, 1'b0, 1'b0, 8'hA1);
    op0(1'b1, 1'b0, 1'b0, 8'hB2);
    op0(1'b1, 1'b1, 1'b0, 8'hC3);
    n_cmp++; if (c0 !== 3'd2)   begin n_bad++; $display("FAIL repl_count got %0d want 2", c0); end
    n_cmp++; if (d0 !== 8'hC3)  begin n_bad++; $display("FAIL repl_data got %h want c3", d0); end
    n_cmp++; if (er0 !== 1'b0)  begin n_bad++; $display("FAIL repl_error got %b want 0", er0); end
    op0(1'b0, 1'b1, 1'b0, 8'h00);
    n_cmp++; if (d0 !== 8'hA1)  begin n_bad++; $display("FAIL repl_pop_data got %h want a1", d0); end
    n_cmp++; if (c0 !== 3'd1)   begin n_bad++; $display("FAIL repl_pop_count got %0d want 1", c0); end
    op0(1'b0, 1'b1, 1'b0, 8'h00);
    op0(1'b1, 1'b1, 1'b0, 8'h77);
    n_cmp++; if (ec0 !== 2'b10) begin n_bad++; $display("FAIL repl_empty_code got %b want 10", ec0); end
    n_cmp++; if (c0 !== 3'd0)   begin n_bad++; $display("FAIL repl_empty_count got %0d want 0", c0); end
    n_cmp++; if (d0 !== 8'h00)  begin n_bad++; $display("FAIL repl_empty_data got %h want 00", d0); end
  endtask

  task automatic test_full_replace_and_collision;
    for (int i = 1; i <= 4; i++) op0(1'b1, 1'b0, 1'b0, 8'(i));
    op0(1'b1, 1'b0, 1'b1, 8'h99);
    n_cmp++; if (er0 !== 1'b1)  begin n_bad++; $display("FAIL collide_error got %b want 1", er0); end
    n_cmp++; if (ec0 !== 2'b01) begin n_bad++; $display("FAIL collide_code got %b want 01", ec0); end
    n_cmp++; if (d0 !== 8'h04)  begin n_bad++; $display("FAIL collide_data got %h want 04", d0); end
    op0(1'b0, 1'b0, 1'b1, 8'h00);
    op0(1'b1, 1'b1, 1'b0, 8'hEE);
    n_cmp++; if (c0 !== 3'd4)   begin n_bad++; $display("FAIL full_repl_count got %0d want 4", c0); end
    n_cmp++; if (d0 !== 8'hEE)  begin n_bad++; $display("FAIL full_repl_data got %h want ee", d0); end
    n_cmp++; if (er0 !== 1'b0)  begin n_bad++; $display("FAIL full_repl_error got %b want 0", er0); end
    op0(1'b0, 1'b1, 1'b0, 8'h00);
    n_cmp++; if (d0 !== 8'h03)  begin n_bad++; $display("FAIL full_repl_pop got %h want 03", d0); end
  endtask

  task automatic test_debounce;
    // Short glitch: three high cycles, never reaches five stable cycles.
    @(negedge clk); push1 = 1'b1; din1 = 8'h3C;
    repeat (3) @(negedge clk);
    push1 = 1'b0;
    repeat (15) @(negedge clk);
    n_cmp++; if (c1 !== 5'd0) begin n_bad++; $display("FAIL glitch_count got %0d want 0", c1); end
    // Held switch: update lands on edge E+8 where E is the first sampling edge.
    din1 = 8'h5A;
    @(negedge clk); push1 = 1'b1;
    repeat (8) @(negedge clk);
    n_cmp++; if (c1 !== 5'd0)  begin n_bad++; $display("FAIL db_early_count got %0d want 0", c1); end
    @(negedge clk);
    n_cmp++; if (c1 !== 5'd1)  begin n_bad++; $display("FAIL db_latency_count got %0d want 1", c1); end
    n_cmp++; if (d1 !== 8'h5A) begin n_bad++; $display("FAIL db_latency_data got %h want 5a", d1); end
    repeat (41) @(negedge clk);
    push1 = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++; if (c1 !== 5'd1)  begin n_bad++; $display("FAIL db_single_count got %0d want 1", c1); end
  endtask

  task automatic test_non_pow2;
    for (int i = 0; i < 5; i++) op2(1'b1, 8'(8'h10 + i));
    n_cmp++; if (c2 !== 3'd5)  begin n_bad++; $display("FAIL np2_count got %0d want 5", c2); end
    n_cmp++; if (f2 !== 1'b1)  begin n_bad++; $display("FAIL np2_full got %b want 1", f2); end
    n_cmp++; if (d2 !== 8'h14) begin n_bad++; $display("FAIL np2_data got %h want 14", d2); end
    @(negedge clk); push2 = 1'b1; din2 = 8'h66; rst2 = 1'b1;
    @(negedge clk); push2 = 1'b0; rst2 = 1'b0;
    n_cmp++; if (c2 !== 3'd0)  begin n_bad++; $display("FAIL np2_rst_count got %0d want 0", c2); end
    n_cmp++; if (d2 !== 8'h00) begin n_bad++; $display("FAIL np2_rst_data got %h want 00", d2); end
    n_cmp++; if (er2 !== 1'b0) begin n_bad++; $display("FAIL np2_rst_error got %b want 0", er2); end
    n_cmp++; if (e2 !== 1'b1)  begin n_bad++; $display("FAIL np2_rst_empty got %b want 1", e2); end
  endtask

  initial begin
    test_reset;
    test_push_full;
    test_pop_errors;
    test_replace;
    test_full_replace_and_collision;
    test_debounce;
    test_non_pow2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
